// File: rtl/traffic_ctrl_pkg.sv
// Shared definitions for the traffic controller: state codes, lamp
// encodings and the dwell-counter width.
package traffic_defs;

  localparam int DWELL_W = 4;

  // 3-bit state codes, also exported on the debug state port
  typedef enum logic [2:0] {
    NS_G   = 3'd0,
    NS_Y   = 3'd1,
    AR_A   = 3'd2,
    WALK_A = 3'd3,
    EW_G   = 3'd4,
    EW_Y   = 3'd5,
    AR_B   = 3'd6,
    WALK_B = 3'd7
  } state_e;

  // Lamp one-hot ordering is {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // A zero dwell would never expire cleanly, so it is promoted to one tick
  function automatic logic [DWELL_W-1:0] clamp_dur(input logic [DWELL_W-1:0] p);
    return (p == '0) ? DWELL_W'(1) : p;
  endfunction

endpackage

// File: rtl/traffic_ctrl_dwell_timer.sv
// Dwell counter: counts ticks since state entry and flags the final tick.
module dwell_timer
  import traffic_defs::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               tick,
  input  logic [DWELL_W-1:0] dur,
  output logic               done
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // done fires on the tick that completes the dwell; clr restarts from zero
  always_comb begin
    cnt_d = cnt_q;
    done  = tick && (cnt_q == (dur - DWELL_W'(1)));
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Two-phase intersection controller with optional pedestrian walk phase
// after each all-red clearance. Moore FSM; outputs decode from state only.
module traffic_ctrl
  import traffic_defs::*;
#(
  parameter logic [DWELL_W-1:0] T_GREEN  = 4'd8,
  parameter logic [DWELL_W-1:0] T_YELLOW = 4'd2,
  parameter logic [DWELL_W-1:0] T_ALLRED = 4'd1,
  parameter logic [DWELL_W-1:0] T_WALK   = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  state_e             state_q, state_d;
  logic               ped_pending_q, ped_pending_d;
  logic [DWELL_W-1:0] dur;
  logic               done;
  logic               in_walk;

  // Every done is a state change, so the same pulse clears the dwell counter
  dwell_timer u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (done),
    .tick (tick),
    .dur  (dur),
    .done (done)
  );

  // Next-state, dwell select and pedestrian latch
  always_comb begin
    state_d       = state_q;
    ped_pending_d = ped_pending_q;
    dur           = clamp_dur(T_GREEN);
    in_walk       = (state_q == WALK_A) || (state_q == WALK_B);
    unique case (state_q)
      NS_G, EW_G:     dur = clamp_dur(T_GREEN);
      NS_Y, EW_Y:     dur = clamp_dur(T_YELLOW);
      AR_A, AR_B:     dur = clamp_dur(T_ALLRED);
      WALK_A, WALK_B: dur = clamp_dur(T_WALK);
      default:        dur = clamp_dur(T_GREEN);
    endcase
    if (done) begin
      unique case (state_q)
        NS_G:    state_d = NS_Y;
        NS_Y:    state_d = AR_A;
        AR_A:    state_d = ped_pending_q ? WALK_A : EW_G;
        WALK_A:  state_d = EW_G;
        EW_G:    state_d = EW_Y;
        EW_Y:    state_d = AR_B;
        AR_B:    state_d = ped_pending_q ? WALK_B : NS_G;
        WALK_B:  state_d = NS_G;
        default: state_d = NS_G;
      endcase
    end
    // Entering a walk phase services the request and beats a same-edge press
    if (ped_req && !in_walk) begin
      ped_pending_d = 1'b1;
    end
    if (done && ((state_d == WALK_A) || (state_d == WALK_B))) begin
      ped_pending_d = 1'b0;
    end
  end

  // State and pedestrian-latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= NS_G;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Moore output decode: lamps, walk and debug state
  always_comb begin
    ns_lamp     = LAMP_RED;
    ew_lamp     = LAMP_RED;
    walk        = 1'b0;
    ped_pending = ped_pending_q;
    state       = state_q;
    unique case (state_q)
      NS_G:           ns_lamp = LAMP_GRN;
      NS_Y:           ns_lamp = LAMP_YEL;
      EW_G:           ew_lamp = LAMP_GRN;
      EW_Y:           ew_lamp = LAMP_YEL;
      WALK_A, WALK_B: walk = 1'b1;
      default:        ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed, table-driven bench for traffic_ctrl with default timing.
module tb_traffic_ctrl;
  import traffic_defs::*;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef struct {
    logic   rst;
    logic   tick;
    logic   ped;
    state_e exp_st;
    logic   exp_pend;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_lamp, ew_lamp, state;
  logic       walk, ped_pending;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  vec_t vecs[$];

  traffic_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .ped_req     (ped_req),
    .ns_lamp     (ns_lamp),
    .ew_lamp     (ew_lamp),
    .walk        (walk),
    .ped_pending (ped_pending),
    .state       (state)
  );

  // Clock
  always #5 clk = ~clk;

  // Green lamp and walk must never coexist
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (walk && (ns_lamp == GRN || ew_lamp == GRN)) begin
        n_fail++;
        $display("FAIL green_vs_walk: ns=%b ew=%b walk=%b, required no green while walk", ns_lamp, ew_lamp, walk);
      end
    end
  end

  function automatic logic [2:0] exp_ns(input state_e s);
    return (s == NS_G) ? GRN : (s == NS_Y) ? YEL : RED;
  endfunction

  function automatic logic [2:0] exp_ew(input state_e s);
    return (s == EW_G) ? GRN : (s == EW_Y) ? YEL : RED;
  endfunction

  task automatic add(input logic r, input logic t, input logic p,
                     input state_e s, input logic pend, input int n);
    vec_t v;
    v.rst = r; v.tick = t; v.ped = p; v.exp_st = s; v.exp_pend = pend;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  initial begin
    // Free-running, no pedestrians: two full 22-cycle rounds
    add(1, 0, 0, NS_G, 0, 2);
    add(0, 1, 0, NS_G, 0, 7);
    for (int r = 0; r < 2; r++) begin
      add(0, 1, 0, NS_Y, 0, 2);
      add(0, 1, 0, AR_A, 0, 1);
      add(0, 1, 0, EW_G, 0, 8);
      add(0, 1, 0, EW_Y, 0, 2);
      add(0, 1, 0, AR_B, 0, 1);
      add(0, 1, 0, NS_G, 0, 8);
    end

    // One-cycle press in NS_G cycle 3 leads to WALK_A; reset beats tick/ped
    add(1, 1, 1, NS_G, 0, 2);
    add(0, 1, 0, NS_G, 0, 2);
    add(0, 1, 1, NS_G, 1, 1);
    add(0, 1, 0, NS_G, 1, 4);
    add(0, 1, 0, NS_Y, 1, 2);
    add(0, 1, 0, AR_A, 1, 1);
    add(0, 1, 0, WALK_A, 0, 4);
    add(0, 1, 0, EW_G, 0, 3);

    // Press on AR_A exit edge, on WALK_B entry edge, and during WALK_B
    add(1, 0, 0, NS_G, 0, 2);
    add(0, 1, 0, NS_G, 0, 7);
    add(0, 1, 0, NS_Y, 0, 2);
    add(0, 1, 0, AR_A, 0, 1);
    add(0, 1, 1, EW_G, 1, 1);
    add(0, 1, 0, EW_G, 1, 7);
    add(0, 1, 0, EW_Y, 1, 2);
    add(0, 1, 0, AR_B, 1, 1);
    add(0, 1, 1, WALK_B, 0, 2);
    add(0, 1, 0, WALK_B, 0, 2);
    add(0, 1, 0, NS_G, 0, 2);

    // Tick every 5th cycle: NS_G spans 40 cycles
    add(1, 0, 0, NS_G, 0, 2);
    for (int i = 0; i < 40; i++)
      add(0, logic'(i % 5 == 4), 0, (i < 39) ? NS_G : NS_Y, 0, 1);

    // 20-cycle tick freeze mid-NS_G; ped latches while frozen
    add(1, 0, 0, NS_G, 0, 2);
    add(0, 1, 0, NS_G, 0, 3);
    add(0, 0, 0, NS_G, 0, 10);
    add(0, 0, 1, NS_G, 1, 1);
    add(0, 0, 0, NS_G, 1, 9);
    add(0, 1, 0, NS_G, 1, 4);
    add(0, 1, 0, NS_Y, 1, 1);

    // Reset mid-EW_Y with ped pending, then full 8-tick NS_G
    add(1, 0, 0, NS_G, 0, 2);
    add(0, 1, 0, NS_G, 0, 7);
    add(0, 1, 0, NS_Y, 0, 2);
    add(0, 1, 0, AR_A, 0, 1);
    add(0, 1, 0, EW_G, 0, 1);
    add(0, 1, 1, EW_G, 1, 1);
    add(0, 1, 0, EW_G, 1, 6);
    add(0, 1, 0, EW_Y, 1, 1);
    add(0, 0, 0, EW_Y, 1, 2);
    add(1, 1, 0, NS_G, 0, 1);
    add(0, 1, 0, NS_G, 0, 7);
    add(0, 1, 0, NS_Y, 0, 1);

    // ped_req held high: both clearances go to WALK
    add(1, 0, 1, NS_G, 0, 2);
    add(0, 1, 1, NS_G, 1, 7);
    add(0, 1, 1, NS_Y, 1, 2);
    add(0, 1, 1, AR_A, 1, 1);
    add(0, 1, 1, WALK_A, 0, 4);
    add(0, 1, 1, EW_G, 0, 1);
    add(0, 1, 1, EW_G, 1, 7);
    add(0, 1, 1, EW_Y, 1, 2);
    add(0, 1, 1, AR_B, 1, 1);
    add(0, 1, 1, WALK_B, 0, 4);
    add(0, 1, 1, NS_G, 0, 1);
    add(0, 1, 1, NS_G, 1, 1);

    // Apply vectors: drive, clock, sample 1 time unit after the edge
    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].rst;
      tick    = vecs[i].tick;
      ped_req = vecs[i].ped;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      check($sformatf("v%0d state", i), state, 3'(vecs[i].exp_st));
      check($sformatf("v%0d ns_lamp", i), ns_lamp, exp_ns(vecs[i].exp_st));
      check($sformatf("v%0d ew_lamp", i), ew_lamp, exp_ew(vecs[i].exp_st));
      check($sformatf("v%0d walk", i), {2'b00, walk},
            {2'b00, (vecs[i].exp_st == WALK_A || vecs[i].exp_st == WALK_B)});
      check($sformatf("v%0d ped_pending", i), {2'b00, ped_pending}, {2'b00, vecs[i].exp_pend});
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter T_GREEN, default 8: green dwell, in ticks, 4-bit, range 1..15.
REQ-002 Parameter T_YELLOW, default 2: yellow dwell, in ticks, 4-bit.
REQ-003 Parameter T_ALLRED, default 1: all-red clearance dwell, in ticks, 4-bit.
REQ-004 Parameter T_WALK, default 4: pedestrian walk dwell, in ticks, 4-bit.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 tick  input  1  timebase enable from the upstream tick counter; sampled as a level every clk edge.
REQ-008 ped_req  input  1  pedestrian button, already synchronised to clk.
REQ-009 ns_lamp  output  3  north-south lamp, one-hot {red, yellow, green}.
REQ-010 ew_lamp  output  3  east-west lamp, one-hot {red, yellow, green}.
REQ-011 walk  output  1  pedestrian walk signal.
REQ-012 ped_pending  output  1  latched pedestrian request not yet serviced.
REQ-013 state  output  3  current FSM state code, for debug.

Function
REQ-014 The FSM SHALL be Moore, with 8 states:
- NS_G, NS_Y, AR_A, WALK_A, EW_G, EW_Y, AR_B, WALK_B.
- All outputs are decoded from registered state only.
REQ-015 Each state SHALL have a dwell:
- T_GREEN for NS_G and EW_G.
- T_YELLOW for NS_Y and EW_Y.
- T_ALLRED for AR_A and AR_B.
- T_WALK for WALK_A and WALK_B.
- A parameter value of 0 SHALL be treated as 1.
REQ-016 A 4-bit dwell counter SHALL:
- clear to 0 on every state entry;
- increment only on cycles with tick=1.
REQ-017 The state SHALL change on the edge where tick=1 and dwell==DUR-1, so each state lasts exactly DUR ticks.
REQ-018 Transitions SHALL be:
- NS_G -> NS_Y -> AR_A.
- AR_A -> WALK_A if ped_pending, else EW_G.
- WALK_A -> EW_G.
- EW_G -> EW_Y -> AR_B.
- AR_B -> WALK_B if ped_pending, else NS_G.
- WALK_B -> NS_G.
REQ-019 Lamp decode SHALL be:
- NS_G: ns green, ew red.
- NS_Y: ns yellow, ew red.
- EW_G: ew green, ns red.
- EW_Y: ew yellow, ns red.
- AR_*, WALK_*: both red.
REQ-020 walk SHALL be 1 only in WALK_A and WALK_B; a green lamp and walk SHALL never be 1 together.
REQ-021 ped_pending SHALL:
- set on any cycle with ped_req=1 in a non-WALK state;
- stay set until the edge that enters WALK_A or WALK_B, where it clears.
REQ-022 Simultaneous events:
- ped_req=1 on the edge entering WALK: clear wins, so ped_pending=0.
- ped_req during WALK: ignored.
- ped_req on the AR-exit edge: not serviced this AR; ped_pending=1 afterwards.
REQ-023 With tick=0 held, state, dwell and outputs SHALL remain frozen; ped_req latching continues.

Reset
REQ-024 When rst=1 at a posedge, the block SHALL load:
- state NS_G, dwell 0, ped_pending 0.
- Resulting outputs: ns_lamp=green, ew_lamp=red, walk=0, state=NS_G code.
REQ-025 rst SHALL override tick and ped_req, and SHALL take effect mid-dwell from any state within one edge.

Structure
REQ-026 A shared header traffic_defs SHALL hold:
- the 3-bit state codes;
- the lamp one-hot constants;
- the 4-bit dwell width.
REQ-027 The dwell counter SHALL be one sub-module, dwell_timer, with:
- inputs: clk, rst, clr, tick, dur;
- output: done.
REQ-028 The FSM next-state logic and output decode SHALL live in traffic_ctrl.

Verification
REQ-029 rst for 2 cycles, tick=1 constant, no ped_req -> dwells in cycles:
- NS_G 8, NS_Y 2, AR_A 1, EW_G 8, EW_Y 2, AR_B 1;
- the 22-cycle sequence repeats.
REQ-030 ped_req pulsed 1 cycle during NS_G cycle 3, tick=1 -> after NS_Y and AR_A:
- WALK_A for 4 cycles with walk=1 and both lamps red;
- then EW_G;
- ped_pending=0 from WALK_A entry.
REQ-031 tick pulsed every 5th cycle -> NS_G lasts 40 cycles; tick=0 held for 20 cycles mid-NS_G -> no state change.
REQ-032 rst asserted on cycle 3 of EW_Y with ped_pending=1 -> next edge gives NS_G, ped_pending=0, and dwell restarts a full 8 ticks.
REQ-033 ped_req held high from reset -> both AR_A and AR_B enter WALK; no green lamp ever coincides with walk=1 (assertion).
